riscv_decode_stage: RTL and testbench
=====================================

Name: riscv_decode_stage

Overview:
- ID stage of the 5-stage RV32I core: decodes the IF/ID instruction and drives the register file read addresses.
- Returns operands with WB→ID write-through bypass, because the register file writes at the clock edge and reads combinationally.
- Generates immediates and control, detects load-use hazards (stalls IF/ID), and registers everything into the ID/EX pipeline register.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
id_valid_i  in  1  IF/ID holds a valid instruction
id_instr_i  in  32  instruction word
id_pc_i  in  32  instruction PC
flush_i  in  1  branch/jump mispredict from EX; kill ID contents
rf_a1_o, rf_a2_o  out  5  register file read addresses (A1, A2)
rf_rd1_i, rf_rd2_i  in  32  register file read data (RD1, RD2)
wb_we_i  in  1  WB write enable (same signal as regfile WE3)
wb_rd_i  in  5  WB destination (A3)
wb_wd_i  in  32  WB data (WD3)
stall_o  out  1  hold PC and IF/ID this cycle
ex_valid_o  out  1  ID/EX valid
ex_pc_o, ex_rs1_val_o, ex_rs2_val_o, ex_imm_o  out  32  registered PC, operands, immediate
ex_rs1_o, ex_rs2_o, ex_rd_o  out  5  registered register indices
ex_funct3_o  out  3  instr[14:12]
ex_funct7b5_o  out  1  instr[30]
ex_alu_src_imm_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_jump_o, ex_illegal_o  out  1  registered control
ex_wb_sel_o  out  2  00 ALU, 01 load data, 10 PC+4

Behaviour:
- rf_a1_o = instr[19:15], rf_a2_o = instr[24:20]; both are combinational and independent of valid.
- Bypass: rs1 operand = wb_wd_i if wb_we_i && wb_rd_i!=0 && wb_rd_i==rs1, else rf_rd1_i; rs2 is handled identically. Index 0 always yields 0.
- Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Any other opcode: ex_illegal_o=1, and all enables (reg_write/mem_read/mem_write/branch/jump) are 0.
- Immediates are sign-extended from instr[31]:
  - I-type: [31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - U-type: {[31:12],12'b0}.
  - J-type: {[31],[19:12],[20],[30:21],0}.
  - R-type: imm=0.
- ex_reg_write_o is forced to 0 when rd==0.
- JAL/JALR: jump=1, wb_sel=10. LOAD: mem_read=1, wb_sel=01. BRANCH/STORE: reg_write=0.
- uses_rs1 is false for LUI/AUIPC/JAL. uses_rs2 is true only for OP/STORE/BRANCH.
- load_use = id_valid_i && ex_valid_o && ex_mem_read_o && ex_rd_o!=0 && ((uses_rs1 && ex_rd_o==rs1) || (uses_rs2 && ex_rd_o==rs2)).
- stall_o = load_use && !flush_i (combinational).
- Posedge priority: !rst_n > flush_i > load_use > normal.
  - Reset, flush, or stall: load a bubble. ex_valid_o and all control bits go to 0; data fields go to 0 on reset and are don't-care otherwise.
  - Normal: capture the decoded instruction. ex_valid_o=id_valid_i; when id_valid_i=0, all control bits are 0.
- Reset values: every ex_* output is 0; stall_o=0 because ex_valid_o=0.
- Latency: 1 cycle from ID to ID/EX. A load-use hazard costs exactly one bubble; the next cycle's load_use is 0 because ex_mem_read_o is cleared.
- Simultaneous flush and load-use: flush wins; stall_o=0, bubble inserted.
- Reset mid-stall: the bubble is loaded and stall_o drops the cycle after reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid_i=1 → all ex_* outputs 0, stall_o=0. Release: ADDI x5,x0,-3 (0xFFD00293) → ex_imm_o=0xFFFFFFFD, ex_rd_o=5, reg_write=1, alu_src_imm=1.
- Bypass: wb_we_i=1, wb_rd_i=7, wb_wd_i=0xDEADBEEF, rf_rd1_i=0 → ADD x8,x7,x7 yields rs1_val=rs2_val=0xDEADBEEF.
  - Same stimulus with wb_rd_i=0 → operands are rf_rd data.
- Load-use: LW x6,0(x1) followed by ADD x9,x6,x2 → stall_o=1 for one cycle and one bubble (ex_valid_o=0), then the ADD is captured.
  - LUI x9 after the same LW → no stall.
- Flush priority: load-use condition with flush_i=1 → stall_o=0 and ex_valid_o=0 next cycle.
- Immediates and x0 write:
  - BEQ with B-imm -4 (0xFE000EE3) → ex_imm_o=0xFFFFFFFC, branch=1, reg_write=0.
  - JAL x0 → jump=1, reg_write=0, wb_sel=10.
- Illegal: instr 0x0000007F → ex_illegal_o=1, all enables 0, ex_valid_o=1.

Source files
------------

// File: rtl/riscv_decode_stage.sv
// ID stage of the 5-stage RV32I core: decode, operand read with WB write-through,
// immediate generation, load-use hazard detection and the ID/EX pipeline register.
module riscv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic [31:0]     id_instr_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic            flush_i,
  output logic [4:0]      rf_a1_o,
  output logic [4:0]      rf_a2_o,
  input  logic [XLEN-1:0] rf_rd1_i,
  input  logic [XLEN-1:0] rf_rd2_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_wd_i,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_val_o,
  output logic [XLEN-1:0] ex_rs2_val_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic            ex_alu_src_imm_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_reg_write_o,
  output logic            ex_branch_o,
  output logic            ex_jump_o,
  output logic            ex_illegal_o,
  output logic [1:0]      ex_wb_sel_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic       funct7b5;

  assign opcode   = id_instr_i[6:0];
  assign rd       = id_instr_i[11:7];
  assign funct3   = id_instr_i[14:12];
  assign rs1      = id_instr_i[19:15];
  assign rs2      = id_instr_i[24:20];
  assign funct7b5 = id_instr_i[30];

  // Read addresses go straight to the register file regardless of valid.
  assign rf_a1_o = rs1;
  assign rf_a2_o = rs2;

  // ---------------------------------------------------------------- decode
  imm_sel_e   imm_sel;
  logic       d_alu_src_imm;
  logic       d_mem_read;
  logic       d_mem_write;
  logic       d_reg_write_raw;
  logic       d_reg_write;
  logic       d_branch;
  logic       d_jump;
  logic       d_illegal;
  logic [1:0] d_wb_sel;
  logic       uses_rs1;
  logic       uses_rs2;

  always_comb begin
    imm_sel         = IMM_NONE;
    d_alu_src_imm   = 1'b0;
    d_mem_read      = 1'b0;
    d_mem_write     = 1'b0;
    d_reg_write_raw = 1'b0;
    d_branch        = 1'b0;
    d_jump          = 1'b0;
    d_illegal       = 1'b0;
    d_wb_sel        = WB_ALU;
    uses_rs1        = 1'b1;
    uses_rs2        = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm_sel         = IMM_U;
        d_alu_src_imm   = 1'b1;
        d_reg_write_raw = 1'b1;
        uses_rs1        = 1'b0;
      end
      OPC_JAL: begin
        imm_sel         = IMM_J;
        d_reg_write_raw = 1'b1;
        d_jump          = 1'b1;
        d_wb_sel        = WB_PC4;
        uses_rs1        = 1'b0;
      end
      OPC_JALR: begin
        imm_sel         = IMM_I;
        d_alu_src_imm   = 1'b1;
        d_reg_write_raw = 1'b1;
        d_jump          = 1'b1;
        d_wb_sel        = WB_PC4;
      end
      OPC_BRANCH: begin
        imm_sel  = IMM_B;
        d_branch = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        imm_sel         = IMM_I;
        d_alu_src_imm   = 1'b1;
        d_mem_read      = 1'b1;
        d_reg_write_raw = 1'b1;
        d_wb_sel        = WB_LOAD;
      end
      OPC_STORE: begin
        imm_sel       = IMM_S;
        d_alu_src_imm = 1'b1;
        d_mem_write   = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPC_OPIMM: begin
        imm_sel         = IMM_I;
        d_alu_src_imm   = 1'b1;
        d_reg_write_raw = 1'b1;
      end
      OPC_OP: begin
        d_reg_write_raw = 1'b1;
        uses_rs2        = 1'b1;
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
  end

  // Writes to x0 are architecturally dead, so never advertise them downstream.
  assign d_reg_write = d_reg_write_raw && (rd != 5'd0);

  // ------------------------------------------------------------- immediate
  logic [31:0] d_imm;

  always_comb begin
    d_imm = 32'd0;
    case (imm_sel)
      IMM_I: d_imm = {{20{id_instr_i[31]}}, id_instr_i[31:20]};
      IMM_S: d_imm = {{20{id_instr_i[31]}}, id_instr_i[31:25], id_instr_i[11:7]};
      IMM_B: d_imm = {{19{id_instr_i[31]}}, id_instr_i[31], id_instr_i[7],
                      id_instr_i[30:25], id_instr_i[11:8], 1'b0};
      IMM_U: d_imm = {id_instr_i[31:12], 12'd0};
      IMM_J: d_imm = {{11{id_instr_i[31]}}, id_instr_i[31], id_instr_i[19:12],
                      id_instr_i[20], id_instr_i[30:21], 1'b0};
      default: d_imm = 32'd0;
    endcase
  end

  // -------------------------------------------------------------- operands
  // The register file writes on the edge that ends this cycle, so a same-cycle
  // WB to the register being read must be forwarded here.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    if (rs1 == 5'd0)
      rs1_val = '0;
    else if (wb_we_i && (wb_rd_i == rs1))
      rs1_val = wb_wd_i;
    else
      rs1_val = rf_rd1_i;

    if (rs2 == 5'd0)
      rs2_val = '0;
    else if (wb_we_i && (wb_rd_i == rs2))
      rs2_val = wb_wd_i;
    else
      rs2_val = rf_rd2_i;
  end

  // ---------------------------------------------------------------- hazard
  // Handshake: IF/ID offers an instruction with id_valid_i; stall_o is the
  // inverse of ready -- while high, IF/ID and PC must hold the same instruction
  // and this stage inserts a bubble instead of consuming it. flush_i overrides.
  logic load_use;
  logic bubble;

  assign load_use = id_valid_i && ex_valid_o && ex_mem_read_o && (ex_rd_o != 5'd0) &&
                    ((uses_rs1 && (ex_rd_o == rs1)) || (uses_rs2 && (ex_rd_o == rs2)));
  assign stall_o  = load_use && !flush_i;
  assign bubble   = flush_i || load_use;

  // --------------------------------------------------------- ID/EX register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_o       <= 1'b0;
      ex_pc_o          <= '0;
      ex_rs1_val_o     <= '0;
      ex_rs2_val_o     <= '0;
      ex_imm_o         <= '0;
      ex_rs1_o         <= 5'd0;
      ex_rs2_o         <= 5'd0;
      ex_rd_o          <= 5'd0;
      ex_funct3_o      <= 3'd0;
      ex_funct7b5_o    <= 1'b0;
      ex_alu_src_imm_o <= 1'b0;
      ex_mem_read_o    <= 1'b0;
      ex_mem_write_o   <= 1'b0;
      ex_reg_write_o   <= 1'b0;
      ex_branch_o      <= 1'b0;
      ex_jump_o        <= 1'b0;
      ex_illegal_o     <= 1'b0;
      ex_wb_sel_o      <= WB_ALU;
    end else if (bubble) begin
      // Data fields are left as-is; only valid and control matter in a bubble.
      ex_valid_o       <= 1'b0;
      ex_alu_src_imm_o <= 1'b0;
      ex_mem_read_o    <= 1'b0;
      ex_mem_write_o   <= 1'b0;
      ex_reg_write_o   <= 1'b0;
      ex_branch_o      <= 1'b0;
      ex_jump_o        <= 1'b0;
      ex_illegal_o     <= 1'b0;
      ex_wb_sel_o      <= WB_ALU;
    end else begin
      ex_valid_o       <= id_valid_i;
      ex_pc_o          <= id_pc_i;
      ex_rs1_val_o     <= rs1_val;
      ex_rs2_val_o     <= rs2_val;
      ex_imm_o         <= d_imm;
      ex_rs1_o         <= rs1;
      ex_rs2_o         <= rs2;
      ex_rd_o          <= rd;
      ex_funct3_o      <= funct3;
      ex_funct7b5_o    <= funct7b5;
      ex_alu_src_imm_o <= id_valid_i && d_alu_src_imm;
      ex_mem_read_o    <= id_valid_i && d_mem_read;
      ex_mem_write_o   <= id_valid_i && d_mem_write;
      ex_reg_write_o   <= id_valid_i && d_reg_write;
      ex_branch_o      <= id_valid_i && d_branch;
      ex_jump_o        <= id_valid_i && d_jump;
      ex_illegal_o     <= id_valid_i && d_illegal;
      ex_wb_sel_o      <= id_valid_i ? d_wb_sel : WB_ALU;
    end
  end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: reset, bypass, load-use stall,
// flush priority, immediate formats, x0 writes and illegal opcodes.
module tb_riscv_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid_i;
  logic [31:0] id_instr_i;
  logic [31:0] id_pc_i;
  logic        flush_i;
  logic [4:0]  rf_a1_o;
  logic [4:0]  rf_a2_o;
  logic [31:0] rf_rd1_i;
  logic [31:0] rf_rd2_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_wd_i;
  logic        stall_o;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_rs1_val_o;
  logic [31:0] ex_rs2_val_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs1_o;
  logic [4:0]  ex_rs2_o;
  logic [4:0]  ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_funct7b5_o;
  logic        ex_alu_src_imm_o;
  logic        ex_mem_read_o;
  logic        ex_mem_write_o;
  logic        ex_reg_write_o;
  logic        ex_branch_o;
  logic        ex_jump_o;
  logic        ex_illegal_o;
  logic [1:0]  ex_wb_sel_o;

  int n_tests;
  int n_fail;

  localparam logic [31:0] I_ADDI   = 32'hFFD00293; // addi x5,x0,-3
  localparam logic [31:0] I_ADD877 = 32'h00738433; // add  x8,x7,x7
  localparam logic [31:0] I_LW     = 32'h0000A303; // lw   x6,0(x1)
  localparam logic [31:0] I_ADD962 = 32'h002304B3; // add  x9,x6,x2
  localparam logic [31:0] I_LUI    = 32'h123454B7; // lui  x9,0x12345
  localparam logic [31:0] I_BEQ    = 32'hFE000EE3; // beq  x0,x0,-4
  localparam logic [31:0] I_JAL0   = 32'h0080006F; // jal  x0,+8
  localparam logic [31:0] I_SW     = 32'hFE20AC23; // sw   x2,-8(x1)
  localparam logic [31:0] I_ILL    = 32'h0000007F;

  riscv_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_instr_i(id_instr_i), .id_pc_i(id_pc_i),
    .flush_i(flush_i),
    .rf_a1_o(rf_a1_o), .rf_a2_o(rf_a2_o),
    .rf_rd1_i(rf_rd1_i), .rf_rd2_i(rf_rd2_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_wd_i(wb_wd_i),
    .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_rs1_val_o(ex_rs1_val_o), .ex_rs2_val_o(ex_rs2_val_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o),
    .ex_alu_src_imm_o(ex_alu_src_imm_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
    .ex_illegal_o(ex_illegal_o), .ex_wb_sel_o(ex_wb_sel_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    id_valid_i = 1'b1;
    id_instr_i = instr;
    id_pc_i    = pc;
  endtask

  task automatic check_enables(input string tag, input logic rw, input logic mr,
                               input logic mw, input logic br, input logic jp);
    check({tag, ".reg_write"}, {31'd0, ex_reg_write_o}, {31'd0, rw});
    check({tag, ".mem_read"},  {31'd0, ex_mem_read_o},  {31'd0, mr});
    check({tag, ".mem_write"}, {31'd0, ex_mem_write_o}, {31'd0, mw});
    check({tag, ".branch"},    {31'd0, ex_branch_o},    {31'd0, br});
    check({tag, ".jump"},      {31'd0, ex_jump_o},      {31'd0, jp});
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    flush_i    = 1'b0;
    wb_we_i    = 1'b0;
    wb_rd_i    = 5'd0;
    wb_wd_i    = 32'd0;
    rf_rd1_i   = 32'h55555555;
    rf_rd2_i   = 32'h66666666;
    present(I_ADDI, 32'h0000_0100);

    // Reset held two cycles with a valid instruction present.
    tick();
    tick();
    check("rst.valid", {31'd0, ex_valid_o}, 32'd0);
    check("rst.stall", {31'd0, stall_o}, 32'd0);
    check("rst.pc", ex_pc_o, 32'd0);
    check("rst.imm", ex_imm_o, 32'd0);
    check("rst.rs1_val", ex_rs1_val_o, 32'd0);
    check("rst.rs2_val", ex_rs2_val_o, 32'd0);
    check("rst.rd", {27'd0, ex_rd_o}, 32'd0);
    check("rst.rs1", {27'd0, ex_rs1_o}, 32'd0);
    check("rst.rs2", {27'd0, ex_rs2_o}, 32'd0);
    check("rst.funct3", {29'd0, ex_funct3_o}, 32'd0);
    check("rst.funct7b5", {31'd0, ex_funct7b5_o}, 32'd0);
    check("rst.alu_src", {31'd0, ex_alu_src_imm_o}, 32'd0);
    check("rst.illegal", {31'd0, ex_illegal_o}, 32'd0);
    check("rst.wb_sel", {30'd0, ex_wb_sel_o}, 32'd0);
    check_enables("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ADDI x5,x0,-3: x0 source reads as zero despite nonzero rf data.
    rst_n = 1'b1;
    tick();
    check("addi.valid", {31'd0, ex_valid_o}, 32'd1);
    check("addi.imm", ex_imm_o, 32'hFFFFFFFD);
    check("addi.rd", {27'd0, ex_rd_o}, 32'd5);
    check("addi.alu_src", {31'd0, ex_alu_src_imm_o}, 32'd1);
    check("addi.rs1_val", ex_rs1_val_o, 32'd0);
    check("addi.pc", ex_pc_o, 32'h0000_0100);
    check("addi.wb_sel", {30'd0, ex_wb_sel_o}, 32'd0);
    check_enables("addi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // WB->ID bypass on both operands.
    wb_we_i  = 1'b1;
    wb_rd_i  = 5'd7;
    wb_wd_i  = 32'hDEADBEEF;
    rf_rd1_i = 32'd0;
    rf_rd2_i = 32'd0;
    present(I_ADD877, 32'h0000_0104);
    #1;
    check("add.rf_a1", {27'd0, rf_a1_o}, 32'd7);
    check("add.rf_a2", {27'd0, rf_a2_o}, 32'd7);
    tick();
    check("byp.rs1_val", ex_rs1_val_o, 32'hDEADBEEF);
    check("byp.rs2_val", ex_rs2_val_o, 32'hDEADBEEF);
    check("byp.rd", {27'd0, ex_rd_o}, 32'd8);
    check("byp.imm", ex_imm_o, 32'd0);
    check("byp.alu_src", {31'd0, ex_alu_src_imm_o}, 32'd0);
    check("byp.reg_write", {31'd0, ex_reg_write_o}, 32'd1);

    // WB to x0 must not forward.
    wb_rd_i  = 5'd0;
    rf_rd1_i = 32'h11111111;
    rf_rd2_i = 32'h22222222;
    tick();
    check("nobyp.rs1_val", ex_rs1_val_o, 32'h11111111);
    check("nobyp.rs2_val", ex_rs2_val_o, 32'h22222222);
    wb_we_i = 1'b0;

    // Load-use: one stall cycle, one bubble, then the ADD.
    present(I_LW, 32'h0000_0108);
    #1;
    check("lw.stall_pre", {31'd0, stall_o}, 32'd0);
    tick();
    check("lw.mem_read", {31'd0, ex_mem_read_o}, 32'd1);
    check("lw.wb_sel", {30'd0, ex_wb_sel_o}, 32'd1);
    check("lw.rd", {27'd0, ex_rd_o}, 32'd6);
    check("lw.funct3", {29'd0, ex_funct3_o}, 32'd2);
    present(I_ADD962, 32'h0000_010C);
    #1;
    check("lu.stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("lu.bubble_valid", {31'd0, ex_valid_o}, 32'd0);
    check("lu.bubble_mem_read", {31'd0, ex_mem_read_o}, 32'd0);
    check("lu.bubble_reg_write", {31'd0, ex_reg_write_o}, 32'd0);
    check("lu.stall_after", {31'd0, stall_o}, 32'd0);
    tick();
    check("lu.add_valid", {31'd0, ex_valid_o}, 32'd1);
    check("lu.add_rd", {27'd0, ex_rd_o}, 32'd9);
    check("lu.add_rs1", {27'd0, ex_rs1_o}, 32'd6);
    check("lu.add_rs2", {27'd0, ex_rs2_o}, 32'd2);

    // LUI after a load to the same register: no source, no stall.
    present(I_LW, 32'h0000_0110);
    tick();
    present(I_LUI, 32'h0000_0114);
    #1;
    check("lui.stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("lui.valid", {31'd0, ex_valid_o}, 32'd1);
    check("lui.imm", ex_imm_o, 32'h12345000);
    check("lui.rd", {27'd0, ex_rd_o}, 32'd9);

    // Flush wins over load-use.
    present(I_LW, 32'h0000_0118);
    tick();
    present(I_ADD962, 32'h0000_011C);
    flush_i = 1'b1;
    #1;
    check("flush.stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("flush.valid", {31'd0, ex_valid_o}, 32'd0);
    check("flush.mem_read", {31'd0, ex_mem_read_o}, 32'd0);
    flush_i = 1'b0;

    // B-type immediate, branch never writes.
    present(I_BEQ, 32'h0000_0200);
    tick();
    check("beq.imm", ex_imm_o, 32'hFFFFFFFC);
    check_enables("beq", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // JAL x0: jump with write suppressed.
    present(I_JAL0, 32'h0000_0204);
    tick();
    check("jal.imm", ex_imm_o, 32'd8);
    check("jal.wb_sel", {30'd0, ex_wb_sel_o}, 32'd2);
    check_enables("jal", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // S-type immediate.
    present(I_SW, 32'h0000_0208);
    tick();
    check("sw.imm", ex_imm_o, 32'hFFFFFFF8);
    check("sw.alu_src", {31'd0, ex_alu_src_imm_o}, 32'd1);
    check_enables("sw", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Unsupported opcode.
    present(I_ILL, 32'h0000_020C);
    tick();
    check("ill.valid", {31'd0, ex_valid_o}, 32'd1);
    check("ill.illegal", {31'd0, ex_illegal_o}, 32'd1);
    check_enables("ill", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Invalid slot: control cleared.
    present(I_ADDI, 32'h0000_0210);
    id_valid_i = 1'b0;
    tick();
    check("inv.valid", {31'd0, ex_valid_o}, 32'd0);
    check("inv.reg_write", {31'd0, ex_reg_write_o}, 32'd0);
    check("inv.alu_src", {31'd0, ex_alu_src_imm_o}, 32'd0);

    // Reset arriving mid-stall.
    present(I_LW, 32'h0000_0300);
    tick();
    present(I_ADD962, 32'h0000_0304);
    #1;
    check("rststall.stall_pre", {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rststall.valid", {31'd0, ex_valid_o}, 32'd0);
    check("rststall.stall", {31'd0, stall_o}, 32'd0);
    check("rststall.rd", {27'd0, ex_rd_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
